// File: rtl/bbox_overlay_pkg.sv
// Shared box record and validity helper for the bounding-box overlay.
// Pure types and functions: no latency, no flow control.
package bbox_overlay_pkg;

    typedef struct packed {
        logic [15:0] x_start;
        logic [15:0] y_start;
        logic [15:0] x_end;
        logic [15:0] y_end;
    } bbox_t;

    function automatic logic bbox_is_valid(input bbox_t b);
        return (b.x_start <= b.x_end) && (b.y_start <= b.y_end);
    endfunction

endpackage

// File: rtl/bbox_overlay_hit.sv
// Outline hit test for one box at the current pixel position.
// Combinational: zero latency, no flow control.
module bbox_hit
    import bbox_overlay_pkg::*;
#(
    parameter int LINE_WIDTH = 2
)(
    input  bbox_t       i_box,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_en,
    output logic        o_hit
);

    localparam logic [16:0] LW = 17'(LINE_WIDTH);

    // 17-bit operands so xs+LW and x+LW cannot wrap near 16'hFFFF
    logic [16:0] w_x, w_y, w_xs, w_xe, w_ys, w_ye;
    logic        w_inside, w_border;

    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_xs = {1'b0, i_box.x_start};
    assign w_xe = {1'b0, i_box.x_end};
    assign w_ys = {1'b0, i_box.y_start};
    assign w_ye = {1'b0, i_box.y_end};

    assign w_inside = (w_xs <= w_x) && (w_x <= w_xe) && (w_ys <= w_y) && (w_y <= w_ye);
    assign w_border = (w_x < w_xs + LW) || (w_x + LW > w_xe) ||
                      (w_y < w_ys + LW) || (w_y + LW > w_ye);

    assign o_hit = i_en && bbox_is_valid(i_box) && w_inside && w_border;

endmodule

// File: rtl/bbox_overlay.sv
// Double-buffered bounding-box outline overlay on pass-through RGB video.
// Fixed 2-cycle video latency; box/done strobes are never backpressured (excess boxes are dropped).
module bbox_overlay
    import bbox_overlay_pkg::*;
#(
    parameter int          IMAGE_WIDTH  = 1280,
    parameter int          IMAGE_HEIGHT = 720,
    parameter int          MAX_BOXES    = 16,
    parameter int          LINE_WIDTH   = 2,
    parameter logic [23:0] BOX_COLOR    = 24'hFF0000
)(
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               de,
    input  logic                               hsync,
    input  logic                               vsync,
    input  logic [7:0]                         r,
    input  logic [7:0]                         g,
    input  logic [7:0]                         b,
    input  logic [15:0]                        bbox_x_start,
    input  logic [15:0]                        bbox_y_start,
    input  logic [15:0]                        bbox_x_end,
    input  logic [15:0]                        bbox_y_end,
    input  logic                               bbox_valid,
    input  logic                               done,
    output logic                               de_out,
    output logic                               hsync_out,
    output logic                               vsync_out,
    output logic [7:0]                         r_out,
    output logic [7:0]                         g_out,
    output logic [7:0]                         b_out,
    output logic [$clog2(MAX_BOXES+1)-1:0]     box_count,
    output logic                               overflow
);

    localparam int          CNT_W = $clog2(MAX_BOXES + 1);
    localparam int          IDX_W = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;
    localparam logic [15:0] X_MAX = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] Y_MAX = 16'(IMAGE_HEIGHT - 1);

    bbox_t              r_bank [2][MAX_BOXES];
    logic [CNT_W-1:0]   r_cnt  [2];
    logic               r_wsel, r_frozen, r_swap_pending, r_wovf, r_dovf;
    logic [CNT_W-1:0]   r_box_count;
    logic [15:0]        r_x, r_y;
    logic               r_de1, r_hs1, r_vs1, r_de2, r_hs2, r_vs2;
    logic [23:0]        r_pix1, r_pix2;
    logic [MAX_BOXES-1:0] r_hits1;

    logic               w_vs_rise, w_de_fall, w_swap, w_wsel, w_dsel;
    logic               w_frozen_base, w_wovf_base, w_store, w_drop;
    logic [CNT_W-1:0]   w_cnt_base;
    logic [IDX_W-1:0]   w_wr_idx;
    bbox_t              w_box_in;
    logic [MAX_BOXES-1:0] w_hits;

    // r_de1/r_vs1 double as the previous-cycle de/vsync for edge detection
    assign w_vs_rise = vsync & ~r_vs1;
    assign w_de_fall = ~de & r_de1;
    assign w_swap    = w_vs_rise & r_swap_pending;

    // A swap hands the strobes of the same cycle to the freshly cleared bank
    assign w_wsel        = w_swap ? ~r_wsel : r_wsel;
    assign w_dsel        = ~r_wsel;
    assign w_cnt_base    = w_swap ? '0 : r_cnt[r_wsel];
    assign w_frozen_base = ~w_swap & r_frozen;
    assign w_wovf_base   = ~w_swap & r_wovf;
    assign w_store       = bbox_valid & ~w_frozen_base & (w_cnt_base < CNT_W'(MAX_BOXES));
    assign w_drop        = bbox_valid & ~w_store;
    assign w_wr_idx      = w_cnt_base[IDX_W-1:0];
    assign w_box_in      = {bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wsel         <= 1'b0;
            r_cnt[0]       <= '0;
            r_cnt[1]       <= '0;
            r_frozen       <= 1'b0;
            r_swap_pending <= 1'b0;
            r_wovf         <= 1'b0;
            r_dovf         <= 1'b0;
            r_box_count    <= '0;
        end else begin
            r_wsel         <= w_wsel;
            r_cnt[w_wsel]  <= w_cnt_base + CNT_W'(w_store);
            r_frozen       <= w_frozen_base | done;
            r_wovf         <= w_wovf_base | w_drop;
            r_swap_pending <= (r_swap_pending & ~w_swap) | done;
            if (w_swap) begin
                r_box_count <= r_cnt[r_wsel];
                r_dovf      <= r_wovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store)
            r_bank[w_wsel][w_wr_idx] <= w_box_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (w_de_fall) begin
                r_x <= '0;
                if (r_y != Y_MAX) r_y <= r_y + 16'd1;
            end else if (de && r_x != X_MAX) begin
                r_x <= r_x + 16'd1;
            end
            if (w_vs_rise) r_y <= '0;
        end
    end

    for (genvar i = 0; i < MAX_BOXES; i++) begin : g_hit
        bbox_hit #(.LINE_WIDTH(LINE_WIDTH)) u_hit (
            .i_box (r_bank[w_dsel][i]),
            .i_x   (r_x),
            .i_y   (r_y),
            .i_en  (CNT_W'(i) < r_cnt[w_dsel]),
            .o_hit (w_hits[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_de1   <= 1'b0;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_pix1  <= '0;
            r_hits1 <= '0;
            r_de2   <= 1'b0;
            r_hs2   <= 1'b0;
            r_vs2   <= 1'b0;
            r_pix2  <= '0;
        end else begin
            r_de1   <= de;
            r_hs1   <= hsync;
            r_vs1   <= vsync;
            r_pix1  <= {r, g, b};
            r_hits1 <= w_hits;
            r_de2   <= r_de1;
            r_hs2   <= r_hs1;
            r_vs2   <= r_vs1;
            r_pix2  <= (r_de1 && |r_hits1) ? BOX_COLOR : r_pix1;
        end
    end

    assign de_out    = r_de2;
    assign hsync_out = r_hs2;
    assign vsync_out = r_vs2;
    assign r_out     = r_pix2[23:16];
    assign g_out     = r_pix2[15:8];
    assign b_out     = r_pix2[7:0];
    assign box_count = r_box_count;
    // A pass's drop stays visible while that pass's boxes are on screen
    assign overflow  = r_wovf | r_dovf;

endmodule

// File: tb/tb_bbox_overlay.sv
`timescale 1ns/1ps
module tb_bbox_overlay;

    localparam logic [23:0] C = 24'hFF0000;
    localparam int NP = 34;

    logic        clk = 1'b0;
    logic        reset_n, de, hsync, vsync, bbox_valid, done;
    logic [7:0]  r, g, b;
    logic [15:0] bxs, bys, bxe, bye;
    logic        de_out, hsync_out, vsync_out, overflow;
    logic [7:0]  r_out, g_out, b_out;
    logic [4:0]  box_count;

    always #5 clk = ~clk;

    bbox_overlay #(
        .IMAGE_WIDTH(1280), .IMAGE_HEIGHT(720), .MAX_BOXES(16),
        .LINE_WIDTH(2), .BOX_COLOR(24'hFF0000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .de(de), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b),
        .bbox_x_start(bxs), .bbox_y_start(bys), .bbox_x_end(bxe), .bbox_y_end(bye),
        .bbox_valid(bbox_valid), .done(done),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .box_count(box_count), .overflow(overflow)
    );

    typedef struct { logic de, hs, vs; logic [23:0] rgb; int fr, x, y; } exp_t;
    typedef struct { int fr; int x; int y; logic [23:0] rgb; } probe_t;
    typedef struct { int xs, ys, xe, ye; } box_t;

    exp_t   q[$];
    box_t   disp[$];
    probe_t probes [NP];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, cur_frame = 0, ferr = 0, probe_seen = 0;
    int fe_x, fe_y;
    logic [26:0] fe_got, fe_exp;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic model_hit(input int x, input int y);
        foreach (disp[i]) begin
            if (disp[i].xs <= disp[i].xe && disp[i].ys <= disp[i].ye &&
                x >= disp[i].xs && x <= disp[i].xe && y >= disp[i].ys && y <= disp[i].ye &&
                (x < disp[i].xs + 2 || x + 2 > disp[i].xe || y < disp[i].ys + 2 || y + 2 > disp[i].ye))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input logic d, input logic h, input logic v, input int x, input int y);
        exp_t e;
        logic [23:0] pix, got;
        if (d) pix = {x[7:0], y[7:0], 8'hA5};
        else   pix = {8'h3C, cyc[7:0], 8'hC3};
        de = d; hsync = h; vsync = v;
        {r, g, b} = pix;
        e.de = d; e.hs = h; e.vs = v; e.fr = cur_frame; e.x = x; e.y = y;
        e.rgb = (d && model_hit(x, y)) ? C : pix;
        q.push_back(e);
        @(posedge clk); #1;
        cyc++;
        if (q.size() >= 2) begin
            e = q.pop_front();
            got = {r_out, g_out, b_out};
            if ({de_out, hsync_out, vsync_out, got} !== {e.de, e.hs, e.vs, e.rgb}) begin
                if (ferr == 0) begin
                    fe_x = e.x; fe_y = e.y;
                    fe_got = {de_out, hsync_out, vsync_out, got};
                    fe_exp = {e.de, e.hs, e.vs, e.rgb};
                end
                ferr++;
            end
            if (e.de) begin
                for (int i = 0; i < NP; i++) begin
                    if (probes[i].fr == e.fr && probes[i].x == e.x && probes[i].y == e.y) begin
                        probe_seen++;
                        chk($sformatf("probe_f%0d_x%0d_y%0d", e.fr, e.x, e.y), 64'(got), 64'(probes[i].rgb));
                    end
                end
            end
        end
    endtask

    task automatic stream_check(input string name);
        n_tests++;
        if (ferr != 0) begin
            n_fail++;
            $display("FAIL %s: %0d mismatching cycles, required 0; first at x=%0d y=%0d got %h expected %h",
                     name, ferr, fe_x, fe_y, fe_got, fe_exp);
        end
        ferr = 0;
    endtask

    task automatic frame(input int nlines, input int lo, input int hi, input int long_px, input int short_px);
        int ym, npx;
        cur_frame++;
        step(0, 0, 1, -1, -1); step(0, 0, 1, -1, -1);
        step(0, 0, 0, -1, -1); step(0, 0, 0, -1, -1);
        for (int y = 0; y < nlines; y++) begin
            ym  = (y > 719) ? 719 : y;
            npx = (y >= lo && y <= hi) ? long_px : short_px;
            for (int x = 0; x < npx; x++) step(1, 0, 0, x, ym);
            step(0, 1, 0, -1, -1); step(0, 0, 0, -1, -1); step(0, 0, 0, -1, -1);
        end
        step(0, 0, 0, -1, -1); step(0, 0, 0, -1, -1);
        stream_check($sformatf("frame%0d_pixels", cur_frame));
    endtask

    task automatic write_box(input int xs, input int ys, input int xe, input int ye, input logic d);
        bxs = 16'(xs); bys = 16'(ys); bxe = 16'(xe); bye = 16'(ye);
        bbox_valid = 1'b1; done = d;
        step(0, 0, 0, -1, -1);
        bbox_valid = 1'b0; done = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step(0, 0, 0, -1, -1);
        done = 1'b0;
    endtask

    function automatic box_t mk(input int xs, input int ys, input int xe, input int ye);
        box_t t;
        t.xs = xs; t.ys = ys; t.xe = xe; t.ye = ye;
        return t;
    endfunction

    initial begin
        probes = '{
            '{1, 100, 50, C}, '{1, 163, 50, C}, '{1, 130, 50, C}, '{1, 99, 50, 24'h6332A5},
            '{1, 164, 50, 24'hA432A5}, '{1, 100, 100, C}, '{1, 101, 100, C},
            '{1, 102, 100, 24'h6664A5}, '{1, 161, 100, 24'hA164A5}, '{1, 162, 100, C},
            '{1, 163, 100, C}, '{1, 130, 49, 24'h8231A5}, '{1, 130, 51, C}, '{1, 130, 52, 24'h8234A5},
            '{2, 100, 50, C}, '{2, 15, 2, 24'h0F02A5},
            '{3, 100, 50, 24'h6432A5}, '{3, 10, 5, C}, '{3, 15, 5, 24'h0F05A5},
            '{4, 0, 2, C}, '{4, 61, 3, C}, '{4, 65, 3, 24'h4103A5},
            '{6, 30, 5, C}, '{6, 35, 3, C}, '{6, 35, 5, 24'h2305A5}, '{6, 55, 5, 24'h3705A5},
            '{7, 1275, 710, C}, '{7, 1275, 713, 24'hFBC9A5}, '{7, 1269, 710, 24'hF5C6A5},
            '{7, 1270, 713, C}, '{7, 3, 4, 24'h0304A5},
            '{8, 0, 5, 24'h0005A5},
            '{9, 0, 5, C}, '{9, 5, 5, 24'h0505A5}
        };
        reset_n = 1'b1; de = 0; hsync = 0; vsync = 0; r = 0; g = 0; b = 0;
        bxs = 0; bys = 0; bxe = 0; bye = 0; bbox_valid = 0; done = 0;
        #2 reset_n = 1'b0;
        #1 chk("reset_state", {31'd0, de_out, hsync_out, vsync_out, r_out, g_out, b_out, box_count, overflow}, 64'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // single box, then swap
        write_box(100, 50, 163, 177, 1'b0);
        pulse_done();
        chk("count_before_swap", 64'(box_count), 64'd0);
        disp = '{mk(100, 50, 163, 177)};
        frame(102, 0, 101, 166, 166);
        chk("count_box_a", 64'(box_count), 64'd1);
        chk("ovf_box_a", 64'(overflow), 64'd0);

        // no done: old overlay persists, new box waits
        write_box(10, 2, 20, 8, 1'b0);
        frame(52, 0, 51, 166, 166);
        chk("count_persist", 64'(box_count), 64'd1);
        pulse_done();
        disp = '{mk(10, 2, 20, 8)};
        frame(52, 0, 51, 166, 166);
        chk("count_box_b", 64'(box_count), 64'd1);

        // 17 boxes into a 16-entry bank
        for (int i = 0; i < 16; i++) write_box(4 * i, 2, 4 * i + 2, 5, 1'b0);
        chk("ovf_at_16", 64'(overflow), 64'd0);
        write_box(64, 2, 66, 5, 1'b0);
        chk("ovf_at_17", 64'(overflow), 64'd1);
        pulse_done();
        disp.delete();
        for (int i = 0; i < 16; i++) disp.push_back(mk(4 * i, 2, 4 * i + 2, 5));
        frame(10, 0, 9, 72, 72);
        chk("count_full", 64'(box_count), 64'd16);
        chk("ovf_after_full_swap", 64'(overflow), 64'd1);
        pulse_done();
        disp.delete();
        frame(0, 0, 0, 0, 0);
        chk("count_empty_pass", 64'(box_count), 64'd0);
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // box and done together, box one cycle later dropped
        write_box(30, 3, 40, 7, 1'b1);
        chk("ovf_same_cycle", 64'(overflow), 64'd0);
        write_box(50, 3, 60, 7, 1'b0);
        chk("ovf_after_freeze", 64'(overflow), 64'd1);
        disp = '{mk(30, 3, 40, 7)};
        frame(10, 0, 9, 72, 72);
        chk("count_same_cycle", 64'(box_count), 64'd1);

        // inverted box and frame-corner box, lines past the last row saturate y
        write_box(3, 2, 0, 6, 1'b0);
        write_box(1270, 710, 1279, 719, 1'b1);
        disp = '{mk(3, 2, 0, 6), mk(1270, 710, 1279, 719)};
        frame(722, 710, 721, 1280, 4);
        chk("count_corner", 64'(box_count), 64'd2);
        chk("ovf_corner", 64'(overflow), 64'd0);

        // asynchronous reset in the middle of an active line
        cur_frame = 100;
        step(0, 0, 1, -1, -1); step(0, 0, 1, -1, -1); step(0, 0, 0, -1, -1);
        for (int x = 0; x < 6; x++) step(1, 0, 0, x, 0);
        chk("pre_reset_de_out", 64'(de_out), 64'd1);
        stream_check("pre_reset_stream");
        #2 reset_n = 1'b0;
        #1 chk("midline_reset", {31'd0, de_out, hsync_out, vsync_out, r_out, g_out, b_out, box_count, overflow}, 64'd0);
        q.delete();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        cur_frame = 7;
        disp.delete();
        write_box(0, 0, 10, 10, 1'b0);
        frame(12, 0, 11, 20, 20);
        chk("count_after_reset", 64'(box_count), 64'd0);
        pulse_done();
        disp = '{mk(0, 0, 10, 10)};
        frame(12, 0, 11, 20, 20);
        chk("count_after_reset_swap", 64'(box_count), 64'd1);

        step(0, 0, 0, -1, -1); step(0, 0, 0, -1, -1);
        stream_check("tail_stream");
        chk("probes_seen", 64'(probe_seen), 64'(NP));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bbox_overlay.md
# bbox_overlay

Post-detection video stage that consumes the bounding-box stream produced by the SVM detector (`bbox_valid`, `bbox_*_start/end`, `done`) and draws rectangle outlines onto the pass-through RGB video. Boxes collected during one detection pass are double-buffered and shown from the next frame boundary, so the drawn set never changes mid-frame. Sits between the detector top level and the HDMI/VGA output encoder.

## Interface

Parameters:
- `IMAGE_WIDTH`, 1280, active pixels per line
- `IMAGE_HEIGHT`, 720, active lines per frame
- `MAX_BOXES`, 16, box capacity per bank
- `LINE_WIDTH`, 2, outline thickness in pixels (1..8)
- `BOX_COLOR`, 24'hFF0000, outline colour {r,g,b}

Ports:
- Single clock `clk`; reset `reset_n` is asynchronous and active-low. All other inputs are synchronous to `clk`.
- `clk` in 1: pixel clock
- `reset_n` in 1: asynchronous, active-low reset
- `de`, `hsync`, `vsync` in 1 each: input video timing
- `r`, `g`, `b` in 8 each: input pixel
- `bbox_x_start`, `bbox_y_start`, `bbox_x_end`, `bbox_y_end` in 16 each: inclusive box corners, in pixels
- `bbox_valid` in 1: one-cycle strobe, box fields valid
- `done` in 1: one-cycle strobe, detection pass complete
- `de_out`, `hsync_out`, `vsync_out` out 1 each: delayed timing
- `r_out`, `g_out`, `b_out` out 8 each: overlaid pixel
- `box_count` out $clog2(MAX_BOXES+1): number of boxes in the display bank
- `overflow` out 1: sticky per pass; set when a box is dropped

## Operation

- Two banks, each holding `MAX_BOXES` entries plus a count. One bank is the write bank and the other is the display bank.
- Write path:
  - `bbox_valid` with write count < `MAX_BOXES` and not frozen: store the box at index count, then increment count.
  - `bbox_valid` at full, or while frozen: drop the box and set `overflow`.
- `done` freezes the write bank and sets `swap_pending`.
  - `bbox_valid` and `done` in the same cycle: store the box first, then freeze.
- Swap:
  - At a `vsync` rising edge with `swap_pending`, exchange the banks.
  - The new write bank gets count = 0, frozen = 0, and `overflow` cleared.
  - `box_count` takes the new display bank's count.
  - A `done` in the same cycle as the swap applies to the new write bank; the box is stored first, then the bank freezes.
- Without `done` before `vsync`: no swap, the old overlay persists, and accumulation continues.
- Pixel position:
  - `x` increments on each `de` cycle.
  - A `de` falling edge clears `x` and increments `y`.
  - A `vsync` rising edge clears `y`.
  - `x` and `y` saturate at `IMAGE_WIDTH-1` and `IMAGE_HEIGHT-1`.
- Hit test for display entry i, with `LW = LINE_WIDTH`:
  - Inside: `xs<=x<=xe` and `ys<=y<=ye`.
  - Border: `x<xs+LW` or `x+LW>xe` or `y<ys+LW` or `y+LW>ye`.
  - A hit is inside and on the border.
  - Entries with `xs>xe` or `ys>ye`, or with index ≥ count, never hit.
  - Comparisons are done at 17 bits, so there is no wrap near 16'hFFFF.
- Output pixel: `BOX_COLOR` if `de` and any hit, else the input pixel. Blanking pixels pass unchanged.

## Timing

- Fixed latency of 2 `clk` for `de`, `hsync`, `vsync` and pixel alike.
  - Stage 1 registers the per-box hits together with the delayed video.
  - Stage 2 OR-reduces the hits and muxes the colour.
- A box written in cycle t is visible only after the next qualifying swap.
- The swap takes effect on the cycle after the `vsync` rising edge is sampled. The first drawn pixel of the new set is the first `de` of that frame.
- On `reset_n` low, asynchronously:
  - All outputs go to 0.
  - Both counts, `swap_pending`, frozen, `overflow`, `x` and `y` go to 0.
  - Bank contents are don't-care.
- Deasserting `reset_n` mid-frame: no boxes are drawn until the first swap. `y` is wrong until the next `vsync`, which is acceptable.
- Box strobes may arrive at any time, including blanking; there is no handshake or backpressure.

## Structure

- `bbox_overlay_pkg`:
  - typedef `bbox_t` (packed struct: four 16-bit fields)
  - function `bbox_is_valid(bbox_t)`
- Banks are flip-flop arrays of `bbox_t`, sized MAX_BOXES×64 bits; no BRAM, because all entries are compared in parallel.
- Sub-module `bbox_hit`: combinational border test for one box plus `x`, `y`, `LINE_WIDTH` and an enable. Instantiated MAX_BOXES times via generate.

## Test plan

- One box (100,50)-(163,177) is written, then `done`, then a frame.
  - Frame after the swap, line 50: x=100..163 is FF0000.
  - Line 100: only x=100,101,162,163 are coloured.
  - All other pixels equal the input; latency is exactly 2.
- 17 boxes are written before `done`.
  - `box_count`=16 after the swap and `overflow`=1.
  - The 17th box is not drawn.
  - `overflow` clears at the following swap.
- A frame has no `done`: the previous overlay is redrawn unchanged, and boxes written meanwhile appear after the later `done`+`vsync`.
- `bbox_valid` and `done` in the same cycle: the box is stored and drawn. A `bbox_valid` one cycle later is dropped and sets `overflow`.
- Box with `xs`>`xe`, and box (1270,710)-(1279,719):
  - The first box is never drawn.
  - The second is drawn at the frame corner without wrap artifacts.
- `reset_n` pulled low mid-line: all outputs are 0 within the same cycle; after release the video passes through unmodified until the first swap.
